// File: rtl/shift_add_multiplier.sv
// Sequential 4x4 unsigned shift-and-add multiplier.
// One operation takes 4 RUN steps plus a single DONE cycle; the block is
// back in IDLE one edge after the done pulse, so a new start is accepted
// every 6 cycles at most.
module shift_add_multiplier (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] product,
  output logic       done,
  output logic       busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0] r_state;
  logic [7:0] r_mcand;
  logic [3:0] r_mplier;
  logic [7:0] r_sum;
  logic [1:0] r_cnt;
  logic [7:0] r_product;
  logic [7:0] w_addend;
  logic [7:0] w_sum_next;

  // Partial sum after the current step; the final step's addition is
  // folded in here so the product can be captured on the same edge.
  always_comb begin
    w_addend   = r_mplier[0] ? r_mcand : 8'd0;
    w_sum_next = r_sum + w_addend;
  end

  // FSM and datapath: load on start in IDLE, one shift/add per RUN edge,
  // capture the result on the last RUN edge, then one DONE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_mcand   <= 8'd0;
      r_mplier  <= 4'd0;
      r_sum     <= 8'd0;
      r_cnt     <= 2'd0;
      r_product <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand  <= {4'd0, a};
            r_mplier <= b;
            r_sum    <= 8'd0;
            r_cnt    <= 2'd0;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_sum    <= w_sum_next;
          r_mcand  <= {r_mcand[6:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[3:1]};
          r_cnt    <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            r_product <= w_sum_next;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Status flags decode directly from the registered state, so they are
  // glitch-free and mutually exclusive.
  always_comb begin
    busy    = (r_state == S_RUN);
    done    = (r_state == S_DONE);
    product = r_product;
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier.
module tb_shift_add_multiplier;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic [7:0] product;
  logic       done;
  logic       busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] last_prod;

  shift_add_multiplier dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .product (product),
    .done    (done),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance to 1ns after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; a = 4'd0; b = 4'd0;
    #2;
    checks++;
    if (product !== 8'h00 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: product=%h done=%b busy=%b, want 00 0 0", product, done, busy);
    end
    tick(); tick();
    reset = 1'b0;
    last_prod = 8'h00;
  endtask

  // Issue one multiply from IDLE and check the full timeline E0..E5.
  task automatic run_op(input logic [3:0] ia, input logic [3:0] ib,
                        input logic [7:0] exp, input string name);
    start = 1'b1; a = ia; b = ib;
    tick();                      // E0
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || product !== last_prod) begin
        errors++;
        $display("FAIL %s_run%0d: busy=%b done=%b product=%h, want 1 0 %h",
                 name, i, busy, done, product, last_prod);
      end
      tick();                    // E1..E4
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || product !== exp) begin
      errors++;
      $display("FAIL %s_done: done=%b busy=%b product=%h, want 1 0 %h",
               name, done, busy, product, exp);
    end
    tick();                      // E5 -> IDLE
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || product !== exp) begin
      errors++;
      $display("FAIL %s_idle: done=%b busy=%b product=%h, want 0 0 %h",
               name, done, busy, product, exp);
    end
    last_prod = exp;
  endtask

  task automatic test_basic();
    run_op(4'd3, 4'd5, 8'h0F, "mul_3x5");
  endtask

  task automatic test_max();
    run_op(4'd15, 4'd15, 8'hE1, "mul_15x15");
  endtask

  task automatic test_zero();
    run_op(4'd0, 4'd9, 8'h00, "mul_0x9");
    run_op(4'd9, 4'd0, 8'h00, "mul_9x0");
    run_op(4'd2, 4'd3, 8'h06, "mul_2x3");
  endtask

  // start and operands disturbed during RUN must not affect the result
  task automatic test_ignore_start();
    start = 1'b1; a = 4'd6; b = 4'd7;
    tick();                      // E0
    start = 1'b1; a = 4'd2; b = 4'd2;
    tick();                      // E1
    a = 4'd9; b = 4'd9; start = 1'b0;
    tick();                      // E2
    tick();                      // E3
    tick();                      // E4
    checks++;
    if (done !== 1'b1 || product !== 8'h2A) begin
      errors++;
      $display("FAIL ignore_start: done=%b product=%h, want 1 2a", done, product);
    end
    tick();                      // E5
    tick();                      // IDLE edge, start low
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 8'h2A) begin
      errors++;
      $display("FAIL ignore_start_no_requeue: busy=%b done=%b product=%h, want 0 0 2a",
               busy, done, product);
    end
    last_prod = 8'h2A;
  endtask

  task automatic test_reset_mid();
    start = 1'b1; a = 4'd5; b = 4'd5;
    tick();                      // E0
    start = 1'b0;
    tick();                      // E1
    tick();                      // E2
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (product !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_async: product=%h busy=%b done=%b, want 00 0 0",
               product, busy, done);
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || product !== 8'h00) begin
        errors++;
        $display("FAIL reset_mid_quiet%0d: done=%b busy=%b product=%h, want 0 0 00",
                 i, done, busy, product);
      end
      tick();
    end
    last_prod = 8'h00;
    run_op(4'd4, 4'd4, 8'h10, "after_reset_4x4");
  endtask

  task automatic test_back_to_back();
    int last_done;
    int ndone;
    last_done = -1;
    ndone = 0;
    start = 1'b1; a = 4'd1; b = 4'd1;
    for (int cyc = 0; cyc < 24; cyc++) begin
      tick();
      checks++;
      if (done === 1'b1 && busy === 1'b1) begin
        errors++;
        $display("FAIL b2b_exclusive cyc%0d: done=1 busy=1, want not both", cyc);
      end
      if (done === 1'b1) begin
        ndone++;
        checks++;
        if (product !== 8'h01) begin
          errors++;
          $display("FAIL b2b_product cyc%0d: product=%h, want 01", cyc, product);
        end
        if (last_done >= 0) begin
          checks++;
          if (cyc - last_done !== 6) begin
            errors++;
            $display("FAIL b2b_interval: got %0d cycles, want 6", cyc - last_done);
          end
        end
        last_done = cyc;
      end
    end
    start = 1'b0;
    checks++;
    if (ndone !== 4) begin
      errors++;
      $display("FAIL b2b_count: got %0d done pulses, want 4", ndone);
    end
    for (int i = 0; i < 8; i++) tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // hard stop guard so the run always terminates
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
